// File: rtl/wb_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_sequencer
//  Purpose  : Y86-64 SEQ writeback-port sequencer. Decodes dstE/dstM for
//             each retiring instruction and drives the single register-file
//             write port. popq with two distinct destinations is serialised
//             over two cycles, with back-pressure on the upstream stage.
//  Revision : 1.0  initial release
// ============================================================================
module wb_port_sequencer #(
    parameter int RSP_ID  = 4,
    parameter int NONE_ID = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    output logic             wr_en,
    output logic [3:0]       wr_addr,
    output logic [63:0]      wr_data,
    output logic             wb_done,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [3:0] c_RSP  = 4'(RSP_ID);
    localparam logic [3:0] c_NONE = 4'(NONE_ID);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Pending second (M) write, captured on accept.
    logic        r_two;
    logic [3:0]  r_m_addr;
    logic [63:0] r_val_m;

    logic [3:0]  w_raw_e;
    logic [3:0]  w_dst_m;
    logic        w_e_ok;
    logic        w_m_ok;
    logic        w_two;
    logic        w_accept;

    logic        w_en;
    logic [3:0]  w_addr;
    logic [63:0] w_data;
    logic        w_done;

    // Destination decode on the handshake inputs.
    always_comb begin
        w_raw_e = c_NONE;
        w_dst_m = c_NONE;
        case (icode)
            4'h2:             w_raw_e = cnd ? rB : c_NONE;
            4'h3, 4'h6:       w_raw_e = rB;
            4'h5:             w_dst_m = rA;
            4'h8, 4'h9, 4'hA: w_raw_e = c_RSP;
            4'hB: begin
                w_raw_e = c_RSP;
                w_dst_m = rA;
            end
            default: ;
        endcase
    end

    // popq %rsp: the E write collides with the M write and is dropped.
    assign w_e_ok   = (w_raw_e != c_NONE) && (w_raw_e != w_dst_m);
    assign w_m_ok   = (w_dst_m != c_NONE);
    assign w_two    = w_e_ok && w_m_ok;

    assign in_ready = (r_state != SLOT1) || !r_two;
    assign w_accept = in_valid && in_ready;

    // Next state and next port values; the port registers always show the
    // slot that the state register names.
    always_comb begin
        w_next = IDLE;
        w_en   = 1'b0;
        w_addr = wr_addr;
        w_data = wr_data;
        w_done = 1'b0;
        if (w_accept) begin
            w_next = SLOT1;
            w_done = !w_two;
            if (w_e_ok) begin
                w_en   = 1'b1;
                w_addr = w_raw_e;
                w_data = valE;
            end else if (w_m_ok) begin
                w_en   = 1'b1;
                w_addr = w_dst_m;
                w_data = valM;
            end
        end else if ((r_state == SLOT1) && r_two) begin
            w_next = SLOT2;
            w_en   = 1'b1;
            w_addr = r_m_addr;
            w_data = r_val_m;
            w_done = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Capture the pending M write on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_two    <= 1'b0;
            r_m_addr <= 4'd0;
            r_val_m  <= 64'd0;
        end else if (w_accept) begin
            r_two    <= w_two;
            r_m_addr <= w_dst_m;
            r_val_m  <= valM;
        end
    end

    // Registered write port and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= 4'd0;
            wr_data <= 64'd0;
            wb_done <= 1'b0;
        end else begin
            wr_en   <= w_en;
            wr_addr <= w_addr;
            wr_data <= w_data;
            wb_done <= w_done;
        end
    end

    // Retire counter advances once per completion pulse, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       retire_cnt <= '0;
        else if (wb_done) retire_cnt <= retire_cnt + 1'b1;
    end

endmodule
`default_nettype wire
